next_pc_gen: RTL and testbench

//  Fetch-stage PC generator. Owns the architectural fetch PC register and picks the next PC.

---
 rtl/next_pc_pkg.sv | 12 +
 rtl/br_perf_counter.sv | 26 ++
 rtl/next_pc_gen.sv | 110 +++++++++++
 tb/tb_next_pc_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/next_pc_pkg.sv
// next_pc_pkg: shared types, constants and helpers for the fetch PC generator
package next_pc_pkg;

    typedef enum logic [1:0] {NPC_BOOT, NPC_RUN, NPC_HOLD} npc_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/br_perf_counter.sv
// br_perf_counter: saturating event counter, sticks at all-ones
module br_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // increment unless already saturated
    always_comb begin
        cnt_d = (i_inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // counter register, async active-low clear
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/next_pc_gen.sv
// next_pc_gen: fetch PC register with predict/redirect selection, flush and perf counters
module next_pc_gen
    import next_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_br_update_en,
    input  logic             i_br_update_valid,
    input  logic             i_br_update_taken,
    input  logic             i_br_update_already_prd,
    input  logic [31:0]      i_br_update_pc,
    input  logic [31:0]      i_br_update_target,
    input  logic             i_prd_taken,
    input  logic [31:0]      i_prd_target,
    output logic [31:0]      o_pc,
    output logic             o_pc_valid,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    npc_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] held_q, held_d;
    logic        pc_valid_q, pc_valid_d;
    logic        flush_q, flush_d;
    logic        branch;
    logic        mispred;
    logic        cnt_en;
    logic [31:0] redir_pc;
    logic [31:0] seq_pc;

    assign branch   = i_br_update_en & i_br_update_valid;
    assign mispred  = branch & (i_br_update_taken ^ i_br_update_already_prd);
    assign redir_pc = align_pc(i_br_update_taken ? i_br_update_target
                                                 : i_br_update_pc + 32'(INSTR_BYTES));
    assign seq_pc   = pc_q + 32'(INSTR_BYTES);
    assign cnt_en   = (state_q != NPC_HOLD);

    // next-state and next-PC selection; a redirect always beats the predictor
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        held_d     = held_q;
        flush_d    = 1'b0;
        pc_valid_d = 1'b1;
        case (state_q)
            NPC_BOOT: state_d = NPC_RUN;
            NPC_RUN: begin
                if (mispred && !i_stall) begin
                    pc_d    = redir_pc;
                    flush_d = 1'b1;
                end else if (mispred) begin
                    held_d  = redir_pc;
                    state_d = NPC_HOLD;
                end else if (!i_stall) begin
                    pc_d = i_prd_taken ? align_pc(i_prd_target) : seq_pc;
                end
            end
            NPC_HOLD: begin
                if (!i_stall) begin
                    pc_d    = held_q;
                    flush_d = 1'b1;
                    state_d = NPC_RUN;
                end
            end
            default: state_d = NPC_BOOT;
        endcase
    end

    // architectural fetch state, async active-low reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= NPC_BOOT;
            pc_q       <= RESET_PC;
            held_q     <= '0;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            held_q     <= held_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
        end
    end

    br_perf_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (branch & cnt_en),
        .o_cnt (o_branch_cnt)
    );

    br_perf_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (mispred & cnt_en),
        .o_cnt (o_mispredict_cnt)
    );

    assign o_pc       = pc_q;
    assign o_pc_valid = pc_valid_q;
    assign o_flush    = flush_q;

endmodule

// File: tb/tb_next_pc_gen.sv
// tb_next_pc_gen: directed vectors with a queue-based scoreboard for next_pc_gen
module tb_next_pc_gen;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic        f;
        logic [3:0]  b;
        logic [3:0]  m;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_br_update_en = 1'b0;
    logic        i_br_update_valid = 1'b0;
    logic        i_br_update_taken = 1'b0;
    logic        i_br_update_already_prd = 1'b0;
    logic [31:0] i_br_update_pc = '0;
    logic [31:0] i_br_update_target = '0;
    logic        i_prd_taken = 1'b0;
    logic [31:0] i_prd_target = '0;
    logic [31:0] o_pc;
    logic        o_pc_valid;
    logic        o_flush;
    logic [3:0]  o_branch_cnt;
    logic [3:0]  o_mispredict_cnt;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    next_pc_gen #(.RESET_PC(32'h0000_0100), .CNT_W(4)) dut (
        .i_clk                   (i_clk),
        .i_rst                   (i_rst),
        .i_stall                 (i_stall),
        .i_br_update_en          (i_br_update_en),
        .i_br_update_valid       (i_br_update_valid),
        .i_br_update_taken       (i_br_update_taken),
        .i_br_update_already_prd (i_br_update_already_prd),
        .i_br_update_pc          (i_br_update_pc),
        .i_br_update_target      (i_br_update_target),
        .i_prd_taken             (i_prd_taken),
        .i_prd_target            (i_prd_target),
        .o_pc                    (o_pc),
        .o_pc_valid              (o_pc_valid),
        .o_flush                 (o_flush),
        .o_branch_cnt            (o_branch_cnt),
        .o_mispredict_cnt        (o_mispredict_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input exp_t e);
        vectors++;
        if (o_pc !== e.pc || o_pc_valid !== e.v || o_flush !== e.f ||
            o_branch_cnt !== e.b || o_mispredict_cnt !== e.m) begin
            miscompares++;
            $display("FAIL %s: got pc=%h v=%b f=%b b=%0d m=%0d, expected pc=%h v=%b f=%b b=%0d m=%0d",
                     name, o_pc, o_pc_valid, o_flush, o_branch_cnt, o_mispredict_cnt,
                     e.pc, e.v, e.f, e.b, e.m);
        end
    endtask

    task automatic set_in(input logic stall, input logic en, input logic valid,
                          input logic taken, input logic aprd, input logic [31:0] bpc,
                          input logic [31:0] btgt, input logic prd, input logic [31:0] ptgt);
        i_stall                 = stall;
        i_br_update_en          = en;
        i_br_update_valid       = valid;
        i_br_update_taken       = taken;
        i_br_update_already_prd = aprd;
        i_br_update_pc          = bpc;
        i_br_update_target      = btgt;
        i_prd_taken             = prd;
        i_prd_target            = ptgt;
    endtask

    task automatic idle(input logic stall);
        set_in(stall, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic expect_cyc(input logic [31:0] pc, input logic v, input logic f,
                              input logic [3:0] b, input logic [3:0] m);
        q.push_back('{pc: pc, v: v, f: f, b: b, m: m});
        @(negedge i_clk);
    endtask

    // monitor: one expected entry per rising edge while the scoreboard holds work
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("cycle", e);
            end
        end
    end

    initial begin
        idle(0);
        @(negedge i_clk);
        @(negedge i_clk);
        check("reset", '{pc: 32'h100, v: 1'b0, f: 1'b0, b: 4'd0, m: 4'd0});
        i_rst = 1'b1;
        expect_cyc(32'h100, 1, 0, 0, 0);
        expect_cyc(32'h104, 1, 0, 0, 0);
        expect_cyc(32'h108, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h203);
        expect_cyc(32'h200, 1, 0, 0, 0);
        idle(0);
        expect_cyc(32'h204, 1, 0, 0, 0);
        set_in(0, 1, 1, 1, 0, 32'h180, 32'h400, 0, 32'h0);
        expect_cyc(32'h400, 1, 1, 1, 1);
        idle(0);
        expect_cyc(32'h404, 1, 0, 1, 1);
        set_in(0, 1, 1, 1, 1, 32'h190, 32'h404, 0, 32'h0);
        expect_cyc(32'h408, 1, 0, 2, 1);
        set_in(0, 1, 0, 1, 0, 32'h190, 32'h800, 0, 32'h0);
        expect_cyc(32'h40C, 1, 0, 2, 1);
        set_in(1, 1, 1, 0, 1, 32'h300, 32'h0, 0, 32'h0);
        expect_cyc(32'h40C, 1, 0, 3, 2);
        set_in(1, 1, 1, 1, 0, 32'h310, 32'h500, 1, 32'h600);
        expect_cyc(32'h40C, 1, 0, 3, 2);
        idle(1);
        expect_cyc(32'h40C, 1, 0, 3, 2);
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h600);
        expect_cyc(32'h304, 1, 1, 3, 2);
        idle(0);
        expect_cyc(32'h308, 1, 0, 3, 2);
        idle(1);
        expect_cyc(32'h308, 1, 0, 3, 2);
        idle(0);
        expect_cyc(32'h30C, 1, 0, 3, 2);
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFE);
        expect_cyc(32'hFFFF_FFFC, 1, 0, 3, 2);
        idle(0);
        expect_cyc(32'h0, 1, 0, 3, 2);
        set_in(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 32'h0, 0, 32'h0);
        expect_cyc(32'h0, 1, 1, 4, 3);
        set_in(0, 1, 1, 1, 0, 32'h20, 32'h703, 1, 32'h900);
        expect_cyc(32'h700, 1, 1, 5, 4);
        idle(0);
        expect_cyc(32'h704, 1, 0, 5, 4);
        for (int k = 1; k <= 20; k++) begin
            set_in(0, 1, 1, 1, 0, 32'h40, 32'h1000, 0, 32'h0);
            expect_cyc(32'h1000, 1, 1, 4'((5 + k > 15) ? 15 : 5 + k),
                       4'((4 + k > 15) ? 15 : 4 + k));
        end
        idle(0);
        expect_cyc(32'h1004, 1, 0, 15, 15);
        set_in(1, 1, 1, 1, 0, 32'h50, 32'h2000, 0, 32'h0);
        expect_cyc(32'h1004, 1, 0, 15, 15);
        idle(1);
        #2;
        i_rst = 1'b0;
        #1;
        check("async_reset", '{pc: 32'h100, v: 1'b0, f: 1'b0, b: 4'd0, m: 4'd0});
        @(negedge i_clk);
        @(negedge i_clk);
        idle(0);
        i_rst = 1'b1;
        expect_cyc(32'h100, 1, 0, 0, 0);
        expect_cyc(32'h104, 1, 0, 0, 0);
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge i_clk);
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
